// File: rtl/fpu_wb_test_monitor.sv
// -----------------------------------------------------------------------------
// fpu_wb_test_monitor
//   Passive bring-up monitor placed beside the FPU. It snoops acknowledged
//   Wishbone writes to the FPU register block and, CHECK_DLY cycles later,
//   checks that each write landed in the matching FPU-side shadow register.
//   It also follows firmware checkpoint codes (start / pass / all-done) and
//   keeps saturating counts of started, passed and errored tests, plus a
//   per-test timeout.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_cyc/stb/we/ack_i      snooped Wishbone handshake (never driven)
//   wbs_adr_i, wbs_dat_i      snooped address / write data
//   shadow_i                  FPU shadow registers, slice k = [DW*k +: DW]
//   checkbits_i               firmware checkpoint code bus
//   state_o                   0=IDLE 1=RUN 2=DONE 3=TMO
//   test_cnt_o, pass_cnt_o    tests started / passed (saturating)
//   err_cnt_o                 mismatches + aborts + timeouts (saturating)
//   mismatch_map_o            per-register mismatch flags, current test
//   done_o, timeout_o         sticky all-done / timed-out flags
// -----------------------------------------------------------------------------
module fpu_wb_test_monitor #(
   parameter logic [31:0]            BASE_ADR   = 32'h3000_0000,
   parameter int                     NUM_REGS   = 4,
   parameter logic [NUM_REGS*8-1:0]  REG_OFS    = {8'h1c, 8'h24, 8'h04, 8'h00},
   parameter int                     DW         = 32,
   parameter int                     CHECK_DLY  = 2,
   parameter int                     TIMEOUT    = 30000,
   parameter int                     CNT_W      = 8,
   parameter logic [15:0]            CODE_START = 16'hAB60,
   parameter logic [15:0]            CODE_PASS  = 16'hAB61,
   parameter logic [15:0]            CODE_DONE  = 16'hAB62
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic                     wbs_ack_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [DW-1:0]            wbs_dat_i,
   input  logic [NUM_REGS*DW-1:0]   shadow_i,
   input  logic [15:0]              checkbits_i,
   output logic [1:0]               state_o,
   output logic [CNT_W-1:0]         test_cnt_o,
   output logic [CNT_W-1:0]         pass_cnt_o,
   output logic [CNT_W-1:0]         err_cnt_o,
   output logic [NUM_REGS-1:0]      mismatch_map_o,
   output logic                     done_o,
   output logic                     timeout_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_TMO  = 2'd3;

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int SUM_W = CNT_W + 4;

   // Checkpoint tracking
   logic [15:0]          prev_code;
   logic                 code_evt, start_evt, pass_evt, done_evt;

   // Per-register check channels
   logic [DW-1:0]        exp_q [NUM_REGS];
   logic [3:0]           dly_q [NUM_REGS];
   logic [NUM_REGS-1:0]  pend;
   logic [NUM_REGS-1:0]  hit, cmp_now, mm;
   logic [3:0]           mm_cnt;
   logic                 wr_acc;

   // Test sequencing
   logic [TMR_W-1:0]     timer;
   logic                 pass_seen;
   logic [1:0]           state_nxt;
   logic                 start_test, pass_inc, abort, tmo, go_done;
   logic [SUM_W-1:0]     err_sum;
   logic [CNT_W-1:0]     err_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A held code fires once: only a change against last cycle's value counts.
   assign code_evt  = (checkbits_i != prev_code);
   assign start_evt = code_evt && (checkbits_i == CODE_START);
   assign pass_evt  = code_evt && (checkbits_i == CODE_PASS);
   assign done_evt  = code_evt && (checkbits_i == CODE_DONE);

   assign wr_acc = wbs_cyc_i && wbs_stb_i && wbs_we_i && wbs_ack_i;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      hit     = '0;
      cmp_now = '0;
      mm      = '0;
      mm_cnt  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         hit[k]     = wr_acc && (state_o != ST_DONE) &&
                      (wbs_adr_i == BASE_ADR + 32'(REG_OFS[8*k +: 8]));
         // A fresh write on the compare cycle supersedes the old check.
         cmp_now[k] = pend[k] && (dly_q[k] == 4'd1) && !hit[k];
         mm[k]      = cmp_now[k] && (exp_q[k] != shadow_i[DW*k +: DW]);
         mm_cnt     = mm_cnt + 4'(mm[k]);
      end
   end

   always_comb begin
      state_nxt  = state_o;
      start_test = 1'b0;
      pass_inc   = 1'b0;
      abort      = 1'b0;
      tmo        = 1'b0;
      go_done    = 1'b0;
      case (state_o)
         ST_IDLE: begin
            if (done_evt) begin
               state_nxt = ST_DONE;
               go_done   = 1'b1;
            end else if (start_evt) begin
               state_nxt  = ST_RUN;
               start_test = 1'b1;
            end
         end
         ST_RUN: begin
            if (done_evt) begin
               state_nxt = ST_DONE;
               go_done   = 1'b1;
            end else if (start_evt) begin
               abort      = 1'b1;
               start_test = 1'b1;
            end else if (pass_seen && (pend == '0)) begin
               // Waiting on pend lets late writes resolve before scoring.
               state_nxt = ST_IDLE;
               pass_inc  = (mismatch_map_o == '0);
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               state_nxt = ST_TMO;
               tmo       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Mismatches and an abort/timeout in one cycle all add, then saturate.
   always_comb begin
      err_sum = SUM_W'(err_cnt_o) + SUM_W'(mm_cnt) + SUM_W'(abort) + SUM_W'(tmo);
      err_nxt = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         prev_code      <= 16'h0000;
         state_o        <= ST_IDLE;
         test_cnt_o     <= '0;
         pass_cnt_o     <= '0;
         err_cnt_o      <= '0;
         mismatch_map_o <= '0;
         done_o         <= 1'b0;
         timeout_o      <= 1'b0;
         timer          <= '0;
         pass_seen      <= 1'b0;
         pend           <= '0;
         for (int k = 0; k < NUM_REGS; k++) dly_q[k] <= '0;
      end else begin
         prev_code <= checkbits_i;
         state_o   <= state_nxt;
         done_o    <= done_o | go_done;
         timeout_o <= timeout_o | tmo;
         err_cnt_o <= err_nxt;
         if (start_test) test_cnt_o <= sat_inc(test_cnt_o);
         if (pass_inc)   pass_cnt_o <= sat_inc(pass_cnt_o);

         if (start_test) mismatch_map_o <= mm;
         else            mismatch_map_o <= mismatch_map_o | mm;

         if (start_test)            timer <= '0;
         else if (state_o == ST_RUN) timer <= timer + TMR_W'(1);

         if (start_test || (state_nxt != ST_RUN)) pass_seen <= 1'b0;
         else if (pass_evt)                       pass_seen <= 1'b1;

         for (int k = 0; k < NUM_REGS; k++) begin
            if (go_done) begin
               pend[k] <= 1'b0;
            end else if (hit[k]) begin
               pend[k]  <= 1'b1;
               dly_q[k] <= 4'(CHECK_DLY);
            end else if (pend[k]) begin
               dly_q[k] <= dly_q[k] - 4'd1;
               if (dly_q[k] == 4'd1) pend[k] <= 1'b0;
            end
         end
      end
   end

   // NOTE: expected-data storage is not reset; it is only read while its
   // pend bit is set, and pend is reset.
   always_ff @(posedge wb_clk_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
         if (hit[k]) exp_q[k] <= wbs_dat_i;
      end
   end

endmodule
